// File: rtl/ixc_assign_pipe.sv
// Elastic WIDTH-bit R->L carrier with DEPTH valid/ready register stages.
// DEPTH=0 collapses to a combinational assign with the same handshake semantics.
module ixc_assign_pipe #(
    parameter int WIDTH = 72,
    parameter int DEPTH = 2,
    parameter int CW    = (DEPTH < 1) ? 1 : $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] R,
    input  logic             r_valid,
    output logic             r_ready,
    output logic [WIDTH-1:0] L,
    output logic             l_valid,
    input  logic             l_ready,
    input  logic             flush,
    output logic [CW-1:0]    count
);

    generate
        if (DEPTH == 0) begin : g_comb
            // Clock and reset have no function without storage.
            logic unused_clk;
            assign unused_clk = clk ^ rst_n;

            assign L       = R;
            assign l_valid = r_valid & ~flush;
            assign r_ready = l_ready & ~flush;
            assign count   = '0;
        end else begin : g_pipe
            logic [DEPTH-1:0]            v_q, v_d;
            logic [DEPTH-1:0][WIDTH-1:0] d_q, d_d;
            logic [DEPTH-1:0]            rdy;
            logic [CW-1:0]               cnt;

            // A stage can take a word if it is empty or everything downstream can shift.
            always_comb begin
                logic acc;
                rdy = '0;
                acc = l_ready;
                for (int i = DEPTH - 1; i >= 0; i--) begin
                    acc    = acc | ~v_q[i];
                    rdy[i] = acc;
                end
            end

            always_comb begin
                logic             up_v;
                logic [WIDTH-1:0] up_d;
                v_d  = v_q;
                d_d  = d_q;
                up_v = r_valid;
                up_d = R;
                for (int i = 0; i < DEPTH; i++) begin
                    if (flush) begin
                        v_d[i] = 1'b0;
                    end else if (rdy[i]) begin
                        v_d[i] = up_v;
                        d_d[i] = up_d;
                    end
                    up_v = v_q[i];
                    up_d = d_q[i];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q <= '0;
                    d_q <= '0;
                end else begin
                    v_q <= v_d;
                    d_q <= d_d;
                end
            end

            always_comb begin
                cnt = '0;
                for (int i = 0; i < DEPTH; i++) cnt = cnt + CW'(v_q[i]);
            end

            assign r_ready = rdy[0] & ~flush;
            assign l_valid = v_q[DEPTH-1] & ~flush;
            assign L       = d_q[DEPTH-1];
            assign count   = cnt;
        end
    endgenerate

endmodule

// File: tb/tb_ixc_assign_pipe.sv
// Directed bench: DEPTH=2/WIDTH=72 pipe and DEPTH=0/WIDTH=8 pass-through.
module tb_ixc_assign_pipe;
    localparam int W  = 72;
    localparam int CW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, flush, r_valid, l_ready, r_ready, l_valid;
    logic [W-1:0]  R, L;
    logic [CW-1:0] count;

    logic       flush0, r_valid0, l_ready0, r_ready0, l_valid0;
    logic [7:0] R0, L0;
    logic [0:0] count0;

    ixc_assign_pipe #(.WIDTH(W), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .R(R), .r_valid(r_valid), .r_ready(r_ready),
        .L(L), .l_valid(l_valid), .l_ready(l_ready), .flush(flush), .count(count)
    );

    ixc_assign_pipe #(.WIDTH(8), .DEPTH(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .R(R0), .r_valid(r_valid0), .r_ready(r_ready0),
        .L(L0), .l_valid(l_valid0), .l_ready(l_ready0), .flush(flush0), .count(count0)
    );

    typedef struct {
        logic          rst_n, flush, rv, lr;
        logic [W-1:0]  r;
        logic          e_rr, e_lv, chk_l;
        logic [W-1:0]  e_l;
        logic [CW-1:0] e_cnt;
    } vec_t;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(logic rs, logic fl, logic rv, logic [W-1:0] r, logic lr,
                                logic e_rr, logic e_lv, logic chk_l, logic [W-1:0] e_l,
                                logic [CW-1:0] e_cnt);
        vec_t v;
        v.rst_n = rs; v.flush = fl; v.rv = rv; v.r = r; v.lr = lr;
        v.e_rr = e_rr; v.e_lv = e_lv; v.chk_l = chk_l; v.e_l = e_l; v.e_cnt = e_cnt;
        return v;
    endfunction

    localparam logic [W-1:0] AA = {9{8'hAA}};
    localparam logic [W-1:0] P5 = {9{8'h55}};

    vec_t tbl[21];

    initial begin
        // rst, fl, rv, R, lr | r_ready, l_valid, chkL, L, count
        tbl[0]  = mk(1, 0, 1, AA,     0,  1, 0, 0, 0,      0);
        tbl[1]  = mk(1, 0, 1, P5,     0,  1, 0, 0, 0,      1);
        tbl[2]  = mk(1, 0, 1, 'h77,   0,  0, 1, 1, AA,     2);
        tbl[3]  = mk(1, 0, 1, 'h77,   0,  0, 1, 1, AA,     2);
        tbl[4]  = mk(1, 0, 0, 'h0,    1,  1, 1, 1, AA,     2);
        tbl[5]  = mk(1, 0, 1, 'h99,   1,  1, 1, 1, P5,     1);
        tbl[6]  = mk(1, 0, 1, 'h88,   0,  1, 0, 0, 0,      1);
        tbl[7]  = mk(1, 0, 1, 'h123,  1,  1, 1, 1, 'h99,   2);
        tbl[8]  = mk(1, 0, 0, 'h0,    1,  1, 1, 1, 'h88,   2);
        tbl[9]  = mk(1, 0, 0, 'h0,    1,  1, 1, 1, 'h123,  1);
        tbl[10] = mk(1, 0, 1, 'h1,    0,  1, 0, 0, 0,      0);
        tbl[11] = mk(1, 0, 1, 'h2,    0,  1, 0, 0, 0,      1);
        tbl[12] = mk(1, 1, 1, 'h3,    1,  0, 0, 0, 0,      2);
        tbl[13] = mk(1, 0, 1, 'h4,    1,  1, 0, 0, 0,      0);
        tbl[14] = mk(1, 0, 0, 'h0,    1,  1, 0, 0, 0,      1);
        tbl[15] = mk(1, 0, 0, 'h0,    1,  1, 1, 1, 'h4,    1);
        tbl[16] = mk(1, 0, 1, 'h10,   0,  1, 0, 0, 0,      0);
        tbl[17] = mk(1, 0, 1, 'h11,   0,  1, 0, 0, 0,      1);
        tbl[18] = mk(1, 0, 1, 'h12,   0,  0, 1, 1, 'h10,   2);
        tbl[19] = mk(0, 0, 1, 'h13,   0,  1, 0, 1, 0,      0);
        tbl[20] = mk(1, 0, 0, 'h0,    1,  1, 0, 1, 0,      0);

        rst_n = 1'b0; flush = 1'b0; r_valid = 1'b0; l_ready = 1'b0; R = '0;
        flush0 = 1'b0; r_valid0 = 1'b0; l_ready0 = 1'b0; R0 = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_l_valid", W'(l_valid), W'(0));
        chk("reset_L", L, '0);
        chk("reset_count", W'(count), W'(0));
        chk("reset_r_ready", W'(r_ready), W'(1));
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming: words 0..9 back to back, sink always ready.
        for (int k = 0; k <= 12; k++) begin
            logic          e_lv;
            logic [CW-1:0] e_cnt;
            @(negedge clk);
            r_valid = (k < 10);
            R       = W'(k);
            l_ready = 1'b1;
            e_lv  = (k >= 2) && (k <= 11);
            e_cnt = (k == 0 || k == 12) ? 2'd0 : (k == 1 || k == 11) ? 2'd1 : 2'd2;
            #1;
            chk($sformatf("stream%0d_r_ready", k), W'(r_ready), W'(1));
            chk($sformatf("stream%0d_l_valid", k), W'(l_valid), W'(e_lv));
            chk($sformatf("stream%0d_count", k), W'(count), W'(e_cnt));
            if (e_lv) chk($sformatf("stream%0d_L", k), L, W'(k - 2));
        end

        // Back-pressure, full+drain, flush and async reset sequences.
        foreach (tbl[i]) begin
            @(negedge clk);
            rst_n = tbl[i].rst_n; flush = tbl[i].flush; r_valid = tbl[i].rv;
            R = tbl[i].r; l_ready = tbl[i].lr;
            #1;
            chk($sformatf("row%0d_r_ready", i), W'(r_ready), W'(tbl[i].e_rr));
            chk($sformatf("row%0d_l_valid", i), W'(l_valid), W'(tbl[i].e_lv));
            chk($sformatf("row%0d_count", i), W'(count), W'(tbl[i].e_cnt));
            if (tbl[i].chk_l) chk($sformatf("row%0d_L", i), L, tbl[i].e_l);
        end

        // DEPTH=0 pass-through.
        @(negedge clk);
        R0 = 8'h5A; r_valid0 = 1'b1; l_ready0 = 1'b0; flush0 = 1'b0;
        #1;
        chk("d0_L", W'(L0), W'(8'h5A));
        chk("d0_l_valid", W'(l_valid0), W'(1));
        chk("d0_r_ready", W'(r_ready0), W'(0));
        chk("d0_count", W'(count0), W'(0));
        @(negedge clk);
        flush0 = 1'b1; l_ready0 = 1'b1;
        #1;
        chk("d0_flush_l_valid", W'(l_valid0), W'(0));
        chk("d0_flush_r_ready", W'(r_ready0), W'(0));
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            R0 = 8'($urandom); r_valid0 = 1'($urandom); l_ready0 = 1'($urandom);
            flush0 = ($urandom_range(0, 3) == 0);
            #1;
            chk($sformatf("d0_rand%0d_L", k), W'(L0), W'(R0));
            chk($sformatf("d0_rand%0d_l_valid", k), W'(l_valid0), W'(r_valid0 & ~flush0));
            chk($sformatf("d0_rand%0d_r_ready", k), W'(r_ready0), W'(l_ready0 & ~flush0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
